serial_frame_tx: RTL

//   Transmit end of the serial framing link: accepts a parallel DATA_W nibble via load/ready
//   and shifts it out on a single-bit line, one bit per clk.

---
 rtl/serial_frame_tx.sv | 69 ++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: shifts out header, MSB-first payload and optional even parity on one line
module serial_frame_tx #(
  parameter int HDR_W = 4,
  parameter logic [HDR_W-1:0] HDR = 4'b1010,
  parameter int DATA_W = 4,
  parameter int PARITY_EN = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              dout,
  output logic              frame_active,
  output logic              done
);
  localparam int L = HDR_W + DATA_W + PARITY_EN;
  localparam int CW = $clog2(L);
  typedef enum logic [1:0] {IDLE, HEADER, DATA, PARITY} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [L-1:0] sreg, nsreg;
  logic [HDR_W+DATA_W:0] full;
  logic last, accept, ndout, nact, ndone;
  assign last = state != IDLE && cnt == CW'(L - 1);
  assign ready = rst && (state == IDLE || last);
  assign accept = load && ready;
  assign full = {HDR, din, ^din};
  // cnt indexes the bit currently on dout; sreg MSB is that bit
  always_comb begin
    nstate = state;
    ncnt = cnt;
    nsreg = sreg;
    if (accept) begin
      nstate = HEADER;
      ncnt = '0;
      nsreg = L'(full >> (1 - PARITY_EN));
    end else if (last) begin
      nstate = IDLE;
      ncnt = '0;
    end else if (state != IDLE) begin
      ncnt = cnt + 1'b1;
      nsreg = sreg << 1;
      if (state == HEADER && ncnt == CW'(HDR_W)) nstate = DATA;
      else if (state == DATA && ncnt == CW'(HDR_W + DATA_W)) nstate = PARITY;
    end
    nact = nstate != IDLE;
    ndout = nact ? nsreg[L-1] : IDLE_BIT;
    ndone = nact && ncnt == CW'(L - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
      dout <= IDLE_BIT;
      frame_active <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      sreg <= nsreg;
      dout <= ndout;
      frame_active <= nact;
      done <= ndone;
    end
  end
endmodule
